// File: rtl/load_store_buffer.sv
// rtl/load_store_buffer.sv - in-order load/store queue between the ROB and the memory controller
//
// Purpose:
//   Holds one entry per LOAD/STORE in program order. Entries are allocated at ROB issue
//   time, receive their operands later, and leave from the head once the memory
//   transaction for them completes. Loads run as soon as they reach the head with
//   operands (IO loads additionally wait until they are the oldest ROB entry); stores
//   run only after the ROB has committed them.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   rdy                      global stall (0 = hold all state)
//   new_ls_ins_*             allocation request from the ROB
//   rob_head                 ROB head, used to order IO loads
//   ls_info_*                operand delivery for one queued entry
//   commit_*                 ROB commit broadcast
//   rob_flush                misprediction flush
//   lsb_full                 back-pressure to the ROB
//   mem_*                    registered request to / response from the memory controller
//   load_finish*, ld_data    load completion report to the ROB
//   store_finish*            store-operands-ready report to the ROB
module load_store_buffer #(
  parameter int          LSB_SIZE = 8,
  parameter logic [31:0] IO_BASE  = 32'h30000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        new_ls_ins_flag,
  input  logic [3:0]  new_ls_ins_rnm,
  input  logic [3:0]  rob_head,
  input  logic        ls_info_flag,
  input  logic [3:0]  ls_info_rnm,
  input  logic        ls_info_is_store,
  input  logic [2:0]  ls_info_funct3,
  input  logic [31:0] ls_info_addr,
  input  logic [31:0] ls_info_data,
  input  logic        commit_flag,
  input  logic [3:0]  commit_rename,
  input  logic        commit_is_store,
  input  logic        rob_flush,
  output logic        lsb_full,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_len,
  input  logic        mem_done,
  input  logic [31:0] mem_rdata,
  output logic        load_finish,
  output logic [3:0]  load_finish_rename,
  output logic [31:0] ld_data,
  output logic        store_finish,
  output logic [3:0]  store_finish_rename
);

  localparam int LSB_AW = $clog2(LSB_SIZE);

  typedef logic [LSB_AW-1:0] idx_t;
  typedef logic [LSB_AW:0]   cnt_t;

  // S_LOAD_DROP: a flushed load whose memory transaction is still outstanding;
  // the request stays up until the controller answers, then the data is discarded.
  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_WAIT,
    S_STORE_WAIT,
    S_LOAD_DROP
  } state_e;

  // Queue storage
  logic [LSB_SIZE-1:0] valid_q, valid_d;
  logic [LSB_SIZE-1:0] ready_q, ready_d;
  logic [LSB_SIZE-1:0] is_store_q, is_store_d;
  logic [LSB_SIZE-1:0] finished_q, finished_d;
  logic [LSB_SIZE-1:0] committed_q, committed_d;
  logic [3:0]          rnm_q    [LSB_SIZE];
  logic [3:0]          rnm_d    [LSB_SIZE];
  logic [2:0]          funct3_q [LSB_SIZE];
  logic [2:0]          funct3_d [LSB_SIZE];
  logic [31:0]         addr_q   [LSB_SIZE];
  logic [31:0]         addr_d   [LSB_SIZE];
  logic [31:0]         data_q   [LSB_SIZE];
  logic [31:0]         data_d   [LSB_SIZE];

  idx_t   head_q, head_d;
  idx_t   tail_q, tail_d;
  cnt_t   count_q, count_d;
  state_e state_q, state_d;

  // Registered outputs
  logic        mem_req_q, mem_req_d;
  logic        mem_wr_q, mem_wr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  mem_len_q, mem_len_d;
  logic        load_finish_q, load_finish_d;
  logic [3:0]  load_finish_rename_q, load_finish_rename_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        store_finish_q, store_finish_d;
  logic [3:0]  store_finish_rename_q, store_finish_rename_d;

  logic        alloc;
  logic        pop;
  logic        sf_found;
  logic        run;
  cnt_t        ncommit;
  idx_t        idx;
  logic [31:0] ext_data;

  // Load result extension for the head entry
  always_comb begin
    ext_data = mem_rdata;
    case (funct3_q[head_q])
      3'b000:  ext_data = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      3'b001:  ext_data = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'b100:  ext_data = {24'b0, mem_rdata[7:0]};
      3'b101:  ext_data = {16'b0, mem_rdata[15:0]};
      default: ext_data = mem_rdata;
    endcase
  end

  always_comb begin
    valid_d     = valid_q;
    ready_d     = ready_q;
    is_store_d  = is_store_q;
    finished_d  = finished_q;
    committed_d = committed_q;
    rnm_d       = rnm_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    data_d      = data_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    state_d     = state_q;

    mem_req_d             = mem_req_q;
    mem_wr_d              = mem_wr_q;
    mem_addr_d            = mem_addr_q;
    mem_wdata_d           = mem_wdata_q;
    mem_len_d             = mem_len_q;
    ld_data_d             = ld_data_q;
    load_finish_d         = 1'b0;
    load_finish_rename_d  = load_finish_rename_q;
    store_finish_d        = 1'b0;
    store_finish_rename_d = store_finish_rename_q;

    alloc    = new_ls_ins_flag && !rob_flush;
    pop      = 1'b0;
    sf_found = 1'b0;
    run      = 1'b1;
    ncommit  = '0;
    idx      = '0;

    // Memory sequencing on the head entry
    case (state_q)
      S_IDLE: begin
        if (valid_q[head_q] && ready_q[head_q]) begin
          if (!is_store_q[head_q]) begin
            // A load that is about to be flushed is not started.
            if (!rob_flush &&
                ((addr_q[head_q] < IO_BASE) || (rob_head == rnm_q[head_q]))) begin
              mem_req_d   = 1'b1;
              mem_wr_d    = 1'b0;
              mem_addr_d  = addr_q[head_q];
              mem_wdata_d = '0;
              mem_len_d   = funct3_q[head_q][1:0];
              state_d     = S_LOAD_WAIT;
            end
          end else if (committed_q[head_q]) begin
            mem_req_d   = 1'b1;
            mem_wr_d    = 1'b1;
            mem_addr_d  = addr_q[head_q];
            mem_wdata_d = data_q[head_q];
            mem_len_d   = funct3_q[head_q][1:0];
            state_d     = S_STORE_WAIT;
          end
        end
      end
      S_LOAD_WAIT: begin
        if (mem_done) begin
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
          if (!rob_flush) begin
            ld_data_d            = ext_data;
            load_finish_d        = 1'b1;
            load_finish_rename_d = rnm_q[head_q];
            pop                  = 1'b1;
          end
        end else if (rob_flush) begin
          state_d = S_LOAD_DROP;
        end
      end
      S_STORE_WAIT: begin
        if (mem_done) begin
          mem_req_d = 1'b0;
          pop       = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_LOAD_DROP: begin
        if (mem_done) begin
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Oldest ready store not yet reported
    if (!rob_flush) begin
      for (int k = 0; k < LSB_SIZE; k++) begin
        idx = head_q + idx_t'(k);
        if (!sf_found && valid_q[idx] && ready_q[idx] && is_store_q[idx] && !finished_q[idx]) begin
          sf_found              = 1'b1;
          finished_d[idx]       = 1'b1;
          store_finish_d        = 1'b1;
          store_finish_rename_d = rnm_q[idx];
        end
      end
    end

    if (pop) begin
      valid_d[head_q]     = 1'b0;
      ready_d[head_q]     = 1'b0;
      finished_d[head_q]  = 1'b0;
      committed_d[head_q] = 1'b0;
    end

    if (alloc) begin
      valid_d[tail_q]     = 1'b1;
      rnm_d[tail_q]       = new_ls_ins_rnm;
      ready_d[tail_q]     = 1'b0;
      finished_d[tail_q]  = 1'b0;
      committed_d[tail_q] = 1'b0;
    end

    // Operand capture; the tail match lets operands arrive with the allocation itself.
    if (ls_info_flag) begin
      for (int i = 0; i < LSB_SIZE; i++) begin
        if ((valid_q[i] && rnm_q[i] == ls_info_rnm) ||
            (alloc && tail_q == idx_t'(i) && new_ls_ins_rnm == ls_info_rnm)) begin
          ready_d[i]    = 1'b1;
          is_store_d[i] = ls_info_is_store;
          funct3_d[i]   = ls_info_funct3;
          addr_d[i]     = ls_info_addr;
          data_d[i]     = ls_info_data;
        end
      end
    end

    if (commit_flag && commit_is_store) begin
      for (int i = 0; i < LSB_SIZE; i++) begin
        if (valid_q[i] && rnm_q[i] == commit_rename) begin
          committed_d[i] = 1'b1;
        end
      end
    end

    if (rob_flush) begin
      // Committed stores always form a contiguous run starting at the head.
      for (int k = 0; k < LSB_SIZE; k++) begin
        idx = head_q + idx_t'(k);
        if (run && valid_q[idx] && committed_q[idx]) begin
          ncommit = ncommit + cnt_t'(1);
        end else begin
          run = 1'b0;
        end
      end
      for (int k = 0; k < LSB_SIZE; k++) begin
        idx = head_q + idx_t'(k);
        if (cnt_t'(k) >= ncommit) begin
          valid_d[idx]     = 1'b0;
          ready_d[idx]     = 1'b0;
          finished_d[idx]  = 1'b0;
          committed_d[idx] = 1'b0;
        end
      end
      head_d        = head_q + idx_t'(pop);
      tail_d        = head_q + ncommit[LSB_AW-1:0];
      count_d       = ncommit - cnt_t'(pop);
      load_finish_d = 1'b0;
    end else begin
      head_d  = head_q + idx_t'(pop);
      tail_d  = tail_q + idx_t'(alloc);
      count_d = count_q + cnt_t'(alloc) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      ready_q     <= '0;
      is_store_q  <= '0;
      finished_q  <= '0;
      committed_q <= '0;
      for (int i = 0; i < LSB_SIZE; i++) begin
        rnm_q[i]    <= '0;
        funct3_q[i] <= '0;
        addr_q[i]   <= '0;
        data_q[i]   <= '0;
      end
      head_q                <= '0;
      tail_q                <= '0;
      count_q               <= '0;
      state_q               <= S_IDLE;
      mem_req_q             <= 1'b0;
      mem_wr_q              <= 1'b0;
      mem_addr_q            <= '0;
      mem_wdata_q           <= '0;
      mem_len_q             <= '0;
      ld_data_q             <= '0;
      load_finish_q         <= 1'b0;
      load_finish_rename_q  <= '0;
      store_finish_q        <= 1'b0;
      store_finish_rename_q <= '0;
    end else if (rdy) begin
      valid_q               <= valid_d;
      ready_q               <= ready_d;
      is_store_q            <= is_store_d;
      finished_q            <= finished_d;
      committed_q           <= committed_d;
      rnm_q                 <= rnm_d;
      funct3_q              <= funct3_d;
      addr_q                <= addr_d;
      data_q                <= data_d;
      head_q                <= head_d;
      tail_q                <= tail_d;
      count_q               <= count_d;
      state_q               <= state_d;
      mem_req_q             <= mem_req_d;
      mem_wr_q              <= mem_wr_d;
      mem_addr_q            <= mem_addr_d;
      mem_wdata_q           <= mem_wdata_d;
      mem_len_q             <= mem_len_d;
      ld_data_q             <= ld_data_d;
      load_finish_q         <= load_finish_d;
      load_finish_rename_q  <= load_finish_rename_d;
      store_finish_q        <= store_finish_d;
      store_finish_rename_q <= store_finish_rename_d;
    end
  end

  assign lsb_full            = (count_q >= cnt_t'(LSB_SIZE - 2));
  assign mem_req             = mem_req_q;
  assign mem_wr              = mem_wr_q;
  assign mem_addr            = mem_addr_q;
  assign mem_wdata           = mem_wdata_q;
  assign mem_len             = mem_len_q;
  assign load_finish         = load_finish_q;
  assign load_finish_rename  = load_finish_rename_q;
  assign ld_data             = ld_data_q;
  assign store_finish        = store_finish_q;
  assign store_finish_rename = store_finish_rename_q;

endmodule
